// File: rtl/uart_rx_fifo_if.sv
// UART receive FIFO register-window bundle.
// Master is the MemoryUnit side, slave is the receiver.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic        rd;
  logic        clr_err;
  logic [7:0]  q;
  logic        empty;
  logic [AW:0] count;
  logic        rx_interrupt;
  logic        overflow;
  logic        frame_err;

  modport master (
    output rd, clr_err,
    input  q, empty, count,
    input  rx_interrupt, overflow, frame_err
  );

  modport slave (
    input  rd, clr_err,
    output q, empty, count,
    output rx_interrupt, overflow, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead receive FIFO.
// Raises a one-cycle rx_interrupt for every byte enqueued.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DEPTH        = 16,
  parameter int AW           = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           uart_in,
  uart_rx_fifo_if.slave  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t        state, state_n;
  logic          rx_meta, rxs, rxs_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          tick;
  logic          ld_half, ld_full, shift;
  logic          push_req, ferr_set;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q, count_n;
  logic          empty_q;
  logic          push_ok, pop_ok;
  logic          irq_q, ovf_q, ferr_q;

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
      cnt      <= '0;
      bitn     <= '0;
      sh       <= '0;
    end else begin
      state    <= state_n;
      rx_meta  <= uart_in;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
      if (ld_half)
        cnt <= HALF_LD;
      else if (ld_full)
        cnt <= FULL_LD;
      else if (!tick)
        cnt <= cnt - 1'b1;
      if (state == START)
        bitn <= '0;
      else if (shift)
        bitn <= bitn + 1'b1;
      if (shift)
        sh <= {rxs, sh[7:1]};
    end
  end

  always_comb begin
    state_n  = state;
    ld_half  = 1'b0;
    ld_full  = 1'b0;
    shift    = 1'b0;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE:
        if (rxs_prev && !rxs) begin
          state_n = START;
          ld_half = 1'b1;
        end
      START:
        if (tick) begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            ld_full = 1'b1;
          end
        end
      DATA:
        if (tick) begin
          shift   = 1'b1;
          ld_full = 1'b1;
          if (bitn == 3'd7)
            state_n = STOP;
        end
      STOP:
        if (tick) begin
          push_req = rxs;
          ferr_set = !rxs;
          state_n  = rxs ? IDLE : BRK;
        end
      BRK:
        if (rxs)
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // A same-cycle rd never frees a slot for the incoming byte.
  assign push_ok = push_req && (count_q != FULL_CNT);
  assign pop_ok  = bus.rd && !empty_q;

  always_comb begin
    count_n = count_q;
    if (push_ok && !pop_ok)
      count_n = count_q + 1'b1;
    else if (!push_ok && pop_ok)
      count_n = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= sh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_n;
      empty_q <= (count_n == '0);
      irq_q   <= push_ok;
      if (push_req && !push_ok)
        ovf_q <= 1'b1;
      else if (bus.clr_err)
        ovf_q <= 1'b0;
      if (ferr_set)
        ferr_q <= 1'b1;
      else if (bus.clr_err)
        ferr_q <= 1'b0;
    end
  end

  assign bus.q            = mem[rd_ptr];
  assign bus.empty        = empty_q;
  assign bus.count        = count_q;
  assign bus.rx_interrupt = irq_q;
  assign bus.overflow     = ovf_q;
  assign bus.frame_err    = ferr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Bytes go in as serial frames; queued expectations meet the FIFO head on rd.
module tb_uart_rx_fifo;
  localparam int CPB   = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_in = 1'b1;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH),
    .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_in(uart_in),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int irq_cnt = 0;
  int exp_irq = 0;
  int model_cnt = 0;
  int exp_ovf = 0;
  int exp_ferr = 0;
  logic [7:0] sb [$];

  always @(posedge clk)
    if (bus.rx_interrupt === 1'b1)
      irq_cnt <= irq_cnt + 1;

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(logic v);
    uart_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(int nbits);
    uart_in = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send(logic [7:0] b, logic stopv);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++)
      bit_out(b[i]);
    bit_out(stopv);
    if (stopv) begin
      if (model_cnt < DEPTH) begin
        sb.push_back(b);
        model_cnt++;
        exp_irq++;
      end else begin
        exp_ovf = 1;
      end
    end
  endtask

  task automatic check_state(string tag);
    chk({tag, "_count"}, int'(bus.count), model_cnt);
    chk({tag, "_empty"}, int'(bus.empty), int'(model_cnt == 0));
    chk({tag, "_irqs"}, irq_cnt, exp_irq);
    chk({tag, "_ovf"}, int'(bus.overflow), exp_ovf);
    chk({tag, "_ferr"}, int'(bus.frame_err), exp_ferr);
  endtask

  task automatic pop(string tag);
    int exp;
    exp = (sb.size() > 0) ? int'(sb.pop_front()) : 'h1ff;
    chk({tag, "_nempty"}, int'(bus.empty), 0);
    chk({tag, "_q"}, int'(bus.q), exp);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    if (model_cnt > 0)
      model_cnt--;
  endtask

  task automatic clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.rd = 1'b0;
    bus.clr_err = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_state("reset");
    chk("reset_irq", int'(bus.rx_interrupt), 0);

    // single byte
    idle(2);
    send(8'hA5, 1'b1);
    idle(2);
    check_state("t1");
    pop("t1");
    check_state("t1_after_rd");

    // back-to-back frames with no idle gap
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(2);
    check_state("t2");
    pop("t2a");
    pop("t2b");
    check_state("t2_after_rd");

    // short low glitch is rejected
    uart_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(3);
    check_state("t3");

    // overflow on the 17th byte
    for (int i = 1; i <= 17; i++)
      send(8'(i), 1'b1);
    idle(2);
    check_state("t4");
    for (int i = 0; i < 16; i++)
      pop($sformatf("t4_%0d", i));
    check_state("t4_drained");
    exp_ovf = 0;
    clr();
    check_state("t4_clr");

    // framing error followed by a held-low line
    send(8'h77, 1'b0);
    repeat (5 * CPB) @(negedge clk);
    exp_ferr = 1;
    check_state("t5_ferr");
    exp_ferr = 0;
    clr();
    check_state("t5_clr");
    repeat (35 * CPB) @(negedge clk);
    check_state("t5_once");
    idle(2);
    send(8'h3C, 1'b1);
    idle(2);
    check_state("t5_good");
    pop("t5");

    // reset during bit 4 of a frame
    bit_out(1'b0);
    for (int i = 0; i < 4; i++)
      bit_out(i[0] ? 1'b1 : 1'b0);
    uart_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_state("t6_rst");
    chk("t6_rst_irq", int'(bus.rx_interrupt), 0);
    idle(2);
    send(8'h5A, 1'b1);
    idle(2);
    check_state("t6");
    pop("t6");
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    @(negedge clk);
    check_state("t6_rd_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
